// File: rtl/alu_pkg.sv
// Shared opcode and buffer-state encodings for the ALU write-back stage.
// Optional sticky overflow flag is enabled by defining ALU_WB_STICKY_OVF_EN.
package alu_pkg;

    typedef enum logic [1:0] {
        SEL_ADD = 2'b00,
        SEL_SUB = 2'b01,
        SEL_AND = 2'b10,
        SEL_XOR = 2'b11
    } alu_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } wb_fifo_state_e;

endpackage

// File: rtl/alu_wb_fifo.sv
// Two-entry FIFO with registered head, ready and valid; head reads as zero when empty.
module alu_wb_fifo
    import alu_pkg::*;
#(
    parameter int unsigned W = 70
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    output logic         in_ready,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data
);

    wb_fifo_state_e state;
    logic [W-1:0]   tail;
    logic           pop;

    assign pop = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            rd_data  <= '0;
            tail     <= '0;
            rd_valid <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    in_ready <= 1'b1;
                    if (push) begin
                        rd_data  <= wr_data;
                        rd_valid <= 1'b1;
                        state    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    in_ready <= 1'b1;
                    if (push && pop) begin
                        rd_data <= wr_data;
                    end else if (push) begin
                        tail     <= wr_data;
                        in_ready <= 1'b0;
                        state    <= ST_FULL;
                    end else if (pop) begin
                        rd_data  <= '0;
                        rd_valid <= 1'b0;
                        state    <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Push is impossible here: in_ready is already low.
                    if (pop) begin
                        rd_data  <= tail;
                        tail     <= '0;
                        in_ready <= 1'b1;
                        state    <= ST_ONE;
                    end
                end
                default: begin
                    state    <= ST_EMPTY;
                    rd_data  <= '0;
                    tail     <= '0;
                    rd_valid <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU write-back stage: buffers results, drops writes to register 0, updates status flags on pop.
// Define ALU_WB_STICKY_OVF_EN to make flag_v sticky until ovf_clr.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_overflow,
    input  logic [1:0]        in_select,
    input  logic [ADDR_W-1:0] in_dest,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_dest,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v,
    input  logic              ovf_clr
);

    localparam int unsigned ENTRY_W = DATA_W + ADDR_W + 1;

    logic               arith_op;
    logic               push;
    logic               pop;
    logic               head_ovf;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Logic ops leave a stale overflow on the ALU output; only add/sub keep it.
    assign arith_op = (in_select == SEL_ADD) || (in_select == SEL_SUB);
    assign push     = in_valid && in_ready && (in_dest != '0);
    assign pop      = wb_valid && wb_ready;
    assign wr_entry = {in_overflow && arith_op, in_dest, in_result};
    assign {head_ovf, wb_dest, wb_data} = rd_entry;

    alu_wb_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wr_data  (wr_entry),
        .in_ready (in_ready),
        .rd_valid (wb_valid),
        .rd_ready (wb_ready),
        .rd_data  (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (pop) begin
            flag_z <= (wb_data == '0);
            flag_n <= wb_data[DATA_W-1];
        end
    end

`ifdef ALU_WB_STICKY_OVF_EN
    // Set beats a same-cycle clear so an overflow is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_v <= 1'b0;
        end else if (pop && head_ovf) begin
            flag_v <= 1'b1;
        end else if (ovf_clr) begin
            flag_v <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_v <= 1'b0;
        end else if (pop) begin
            flag_v <= head_ovf;
        end
    end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage with a scoreboard queue and flag model.
// Covers both builds of ALU_WB_STICKY_OVF_EN.
module tb_alu_wb_stage;
    import alu_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  dest;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_result = '0;
    logic        in_overflow = 1'b0;
    logic [1:0]  in_select = 2'b00;
    logic [4:0]  in_dest = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [63:0] wb_data;
    logic [4:0]  wb_dest;
    logic        flag_z, flag_n, flag_v;
    logic        ovf_clr = 1'b0;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic mz = 1'b0, mn = 1'b0, mv = 1'b0;
    logic accepted;

    alu_wb_stage #(.DATA_W(64), .ADDR_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_overflow (in_overflow),
        .in_select   (in_select),
        .in_dest     (in_dest),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_dest     (wb_dest),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_v      (flag_v),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [63:0] res,
                         input logic ovf, input logic [4:0] dest);
        in_valid    = v;
        in_select   = sel;
        in_result   = res;
        in_overflow = ovf;
        in_dest     = dest;
    endtask

    // One clock: update scoreboard/model from the handshakes seen before the edge, then check.
    task automatic tick();
        exp_t e;
        logic rst_edge;
        logic popped;
        rst_edge = reset;
        popped   = 1'b0;
        e        = '0;
        if (reset) begin
            sb.delete();
            mz = 1'b0; mn = 1'b0; mv = 1'b0;
        end else begin
            if (wb_valid && wb_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL wb_extra observed=1 expected=0");
                end else begin
                    e = sb.pop_front();
                    popped = 1'b1;
                    chk("wb_data", wb_data, e.data);
                    chk("wb_dest", 64'(wb_dest), 64'(e.dest));
                    mz = (e.data == 64'd0);
                    mn = e.data[63];
                end
            end
`ifdef ALU_WB_STICKY_OVF_EN
            if (popped && e.ovf) mv = 1'b1;
            else if (ovf_clr) mv = 1'b0;
`else
            if (popped) mv = e.ovf;
`endif
            if (in_valid && in_ready && in_dest != 5'd0)
                sb.push_back('{data: in_result, dest: in_dest,
                               ovf: in_select[1] ? 1'b0 : in_overflow});
        end
        @(posedge clk);
        #1;
        chk("flag_z", 64'(flag_z), 64'(mz));
        chk("flag_n", 64'(flag_n), 64'(mn));
        chk("flag_v", 64'(flag_v), 64'(mv));
        chk("wb_valid", 64'(wb_valid), 64'(sb.size() != 0));
        chk("in_ready", 64'(in_ready), rst_edge ? 64'd0 : 64'(sb.size() < 2));
        if (sb.size() == 0) begin
            chk("wb_data_idle", wb_data, 64'd0);
            chk("wb_dest_idle", 64'(wb_dest), 64'd0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        // Reset and first cycle after release
        tick();
        tick();
        chk("rst_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // Single add result, latency 1, then flags after pop
        wb_ready = 1'b1;
        drive(1'b1, 2'(SEL_ADD), 64'h5, 1'b0, 5'd3);
        tick();
        drive(1'b0, 2'(SEL_ADD), 64'h0, 1'b0, 5'd0);
        chk("t1_valid", 64'(wb_valid), 64'd1);
        chk("t1_data", wb_data, 64'h5);
        chk("t1_dest", 64'(wb_dest), 64'd3);
        tick();
        chk("t1_z", 64'(flag_z), 64'd0);
        chk("t1_n", 64'(flag_n), 64'd0);

        // Back-pressure: third push held while FULL, order kept on release
        wb_ready = 1'b0;
        drive(1'b1, 2'(SEL_ADD), 64'hA1, 1'b0, 5'd4);
        tick();
        drive(1'b1, 2'(SEL_SUB), 64'hB2, 1'b0, 5'd5);
        tick();
        chk("t2_full_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 2'(SEL_XOR), 64'hC3, 1'b0, 5'd6);
        tick();
        tick();
        chk("t2_hold_data", wb_data, 64'hA1);
        chk("t2_hold_dest", 64'(wb_dest), 64'd4);
        wb_ready = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            accepted = in_ready;
            tick();
        end
        chk("t2_third_accepted", 64'(accepted), 64'd1);
        drive(1'b0, 2'(SEL_ADD), 64'h0, 1'b0, 5'd0);
        drain();

        // Logic op with stale overflow and zero result
        drive(1'b1, 2'(SEL_AND), 64'h0, 1'b1, 5'd7);
        tick();
        drive(1'b0, 2'(SEL_ADD), 64'h0, 1'b0, 5'd0);
        tick();
        chk("t3_v", 64'(flag_v), 64'd0);
        chk("t3_z", 64'(flag_z), 64'd1);

        // Write to register 0 is swallowed
        drive(1'b1, 2'(SEL_ADD), 64'h8000_0000_0000_0000, 1'b0, 5'd0);
        tick();
        drive(1'b0, 2'(SEL_ADD), 64'h0, 1'b0, 5'd0);
        chk("t4_no_valid", 64'(wb_valid), 64'd0);
        tick();
        chk("t4_n", 64'(flag_n), 64'd0);
        chk("t4_z", 64'(flag_z), 64'd1);

        // Overflow tracking: sub overflow then clean add
        drive(1'b1, 2'(SEL_SUB), 64'h7FFF_0000_0000_0001, 1'b1, 5'd8);
        tick();
        drive(1'b1, 2'(SEL_ADD), 64'h10, 1'b0, 5'd9);
        tick();
        drive(1'b0, 2'(SEL_ADD), 64'h0, 1'b0, 5'd0);
        chk("t5_v_set", 64'(flag_v), 64'd1);
        tick();
`ifdef ALU_WB_STICKY_OVF_EN
        chk("t5_v_sticky", 64'(flag_v), 64'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5_v_cleared", 64'(flag_v), 64'd0);
        drive(1'b1, 2'(SEL_SUB), 64'h1, 1'b1, 5'd10);
        tick();
        drive(1'b0, 2'(SEL_ADD), 64'h0, 1'b0, 5'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5_set_wins", 64'(flag_v), 64'd1);
`else
        chk("t5_v_follow", 64'(flag_v), 64'd0);
        drive(1'b1, 2'(SEL_SUB), 64'h1, 1'b1, 5'd10);
        tick();
        drive(1'b0, 2'(SEL_ADD), 64'h0, 1'b0, 5'd0);
        ovf_clr = 1'b1;
        tick();
        tick();
        ovf_clr = 1'b0;
        chk("t5_clr_ignored", 64'(flag_v), 64'd1);
`endif

        // Streaming push+pop in ONE, ending with a negative result
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(SEL_ADD), 64'(i + 32), 1'b0, 5'(i + 11));
            tick();
        end
        drive(1'b1, 2'(SEL_XOR), 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 5'd20);
        tick();
        drive(1'b0, 2'(SEL_ADD), 64'h0, 1'b0, 5'd0);
        drain();
        chk("t6_n", 64'(flag_n), 64'd1);

        // Reset while FULL with pending handshakes
        wb_ready = 1'b0;
        drive(1'b1, 2'(SEL_ADD), 64'h111, 1'b0, 5'd21);
        tick();
        drive(1'b1, 2'(SEL_SUB), 64'h222, 1'b1, 5'd22);
        tick();
        chk("t7_full_valid", 64'(wb_valid), 64'd1);
        chk("t7_full_ready", 64'(in_ready), 64'd0);
        reset    = 1'b1;
        wb_ready = 1'b1;
        ovf_clr  = 1'b1;
        tick();
        chk("t7_rst_valid", 64'(wb_valid), 64'd0);
        chk("t7_rst_n", 64'(flag_n), 64'd0);
        chk("t7_rst_v", 64'(flag_v), 64'd0);
        reset   = 1'b0;
        ovf_clr = 1'b0;
        drive(1'b0, 2'(SEL_ADD), 64'h0, 1'b0, 5'd0);
        tick();
        chk("t7_ready_back", 64'(in_ready), 64'd1);
        chk("t7_empty", 64'(wb_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, 64, result/operand width matching the ALU datapath.
REQ-002 SHALL have parameter ADDR_W, 5, destination register index width.
REQ-003 SHALL have port clk input 1, single clock, all state on rising edge.
REQ-004 SHALL have port reset input 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid input 1, ALU result present this cycle.
REQ-006 SHALL have port in_ready output 1, stage can accept a result.
REQ-007 SHALL have port in_result input DATA_W, ALU output s.
REQ-008 SHALL have port in_overflow input 1, ALU overflow output.
REQ-009 SHALL have port in_select input 2, ALU opcode (00 add, 01 sub, 10 and, 11 xor).
REQ-010 SHALL have port in_dest input ADDR_W, destination register index.
REQ-011 SHALL have port wb_valid output 1, write-back request valid.
REQ-012 SHALL have port wb_ready input 1, register file accepts write.
REQ-013 SHALL have port wb_data output DATA_W, data to write.
REQ-014 SHALL have port wb_dest output ADDR_W, register index to write.
REQ-015 SHALL have ports flag_z, flag_n, flag_v output 1 each, zero/negative/overflow status.
REQ-016 SHALL have port ovf_clr input 1, clears sticky overflow (used only when REQ-032 macro defined).

Function
REQ-017 SHALL buffer up to 2 entries {result, overflow_q, dest} in FIFO order; states EMPTY, ONE, FULL.
REQ-018 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL; push occurs when in_valid && in_ready.
REQ-019 SHALL store overflow_q = in_overflow for select 00/01 and force 0 for select 10/11 (ALU holds stale overflow for logic ops).
REQ-020 SHALL present the head entry on wb_data/wb_dest with wb_valid = 1 the cycle after the push (latency 1); pop when wb_valid && wb_ready.
REQ-021 SHALL hold wb_data/wb_dest/wb_valid stable while wb_valid && !wb_ready.
REQ-022 SHALL discard entries with in_dest == 0 at push: accepted (in_ready honoured) but not stored, no wb_valid, no flag update.
REQ-023 SHALL transition EMPTY->ONE on push only, ONE->FULL on push only, ONE->EMPTY on pop only, FULL->ONE on pop only; push+pop in ONE stays ONE with new entry behind head.
REQ-024 SHALL never push in FULL; a pop in FULL reopens in_ready the following cycle.
REQ-025 SHALL update flags on pop only: flag_z = (popped data == 0), flag_n = popped data[DATA_W-1], flag_v per REQ-032.
REQ-026 SHALL drive wb_data/wb_dest to 0 whenever wb_valid = 0.

Reset
REQ-027 SHALL on reset go to EMPTY, discard all entries, drive wb_valid 0, wb_data 0, wb_dest 0.
REQ-028 SHALL on reset drive flag_z 0, flag_n 0, flag_v 0, in_ready 0 during the reset cycle and 1 the cycle after reset deasserts.
REQ-029 SHALL give reset priority over simultaneous push, pop and ovf_clr.

Configuration
REQ-030 SHALL gate the sticky overflow feature on macro ALU_WB_STICKY_OVF_EN.
REQ-031 SHALL, without the macro, set flag_v = overflow_q of the last popped entry and ignore ovf_clr.
REQ-032 SHALL, with the macro, set flag_v on any pop with overflow_q = 1, hold it until ovf_clr = 1; set wins over a same-cycle ovf_clr.

Structure
REQ-033 SHALL place the select opcode encodings (ADD, SUB, AND, XOR) and the state encoding type in a shared package alu_pkg.
REQ-034 SHALL implement the 2-entry buffer as one sub-module alu_wb_fifo; flag logic and discard logic stay in the top.

Verification
REQ-035 SHALL check: push add result 0x5, dest 3, wb_ready 1 -> next cycle wb_valid 1, wb_data 0x5, wb_dest 3; after pop flag_z 0, flag_n 0.
REQ-036 SHALL check: wb_ready 0, three back-to-back pushes -> in_ready 0 after second, third held; order preserved on release.
REQ-037 SHALL check: select 10, in_overflow 1, result 0 -> flag_v 0, flag_z 1 after pop.
REQ-038 SHALL check: push dest 0 value 0x8000_0000_0000_0000 -> no wb_valid, flags unchanged.
REQ-039 SHALL check: with ALU_WB_STICKY_OVF_EN, sub overflow pop then clean add pop -> flag_v stays 1 until ovf_clr; same-cycle set+clr -> 1.
REQ-040 SHALL check: reset asserted while FULL and wb_valid 1 -> next cycle wb_valid 0, all flags 0, buffer EMPTY.
